// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit and imem.
// Single outstanding request; responses are always accepted by the fetch side.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage + IF/ID register; request-accept to ValidD is response latency + 1 edge.
// Backpressure: imem ready stalls pc_f; StallD parks one response in a 1-entry buffer.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master imem,
  input  logic         StallD,
  input  logic         FlushD,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic [31:0]  InstrD,
  output logic [31:0]  PCD,
  output logic [31:0]  PCPlus4D,
  output logic         ValidD
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc_f;
  logic [31:0] issued_pc;
  logic [31:0] buf_instr;
  logic        req_fire;
  logic        dec_take;

  assign imem.imem_req_valid = (state == S_REQ);
  assign imem.imem_req_addr  = pc_f;
  assign req_fire            = imem.imem_req_valid && imem.imem_req_ready;
  assign dec_take            = !StallD && !FlushD;
  assign PCPlus4D            = PCD + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_REQ;
      pc_f      <= RESET_PC;
      issued_pc <= RESET_PC;
      buf_instr <= NOP_INSTR;
      InstrD    <= NOP_INSTR;
      PCD       <= RESET_PC;
      ValidD    <= 1'b0;
    end else begin
      // Bubble unless decode is stalled; flush and redirect beat the stall.
      if (FlushD || redirect_valid || !StallD) begin
        ValidD <= 1'b0;
        InstrD <= NOP_INSTR;
      end

      if (redirect_valid) begin
        pc_f <= redirect_pc & ~32'd3;
        case (state)
          S_REQ:          state <= req_fire ? S_DROP : S_REQ;
          S_WAIT, S_DROP: state <= imem.imem_rsp_valid ? S_REQ : S_DROP;
          default:        state <= S_REQ;
        endcase
      end else begin
        case (state)
          S_REQ: begin
            if (req_fire) begin
              pc_f      <= pc_f + 32'd4;
              issued_pc <= pc_f;
              state     <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem.imem_rsp_valid) begin
              if (dec_take) begin
                InstrD <= imem.imem_rsp_data;
                PCD    <= issued_pc;
                ValidD <= 1'b1;
                state  <= S_REQ;
              end else begin
                buf_instr <= imem.imem_rsp_data;
                state     <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (dec_take) begin
              InstrD <= buf_instr;
              PCD    <= issued_pc;
              ValidD <= 1'b1;
              state  <= S_REQ;
            end
          end
          default: begin
            // Stale response is swallowed without touching IF/ID.
            if (imem.imem_rsp_valid) state <= S_REQ;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter: NOP_INSTR, 32'h0000_0013, instruction (addi x0,x0,0) driven on InstrD when the slot is invalid.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 imem_req_valid  out  1  fetch request valid.
REQ-007 imem_req_ready  in  1  memory accepts the request.
REQ-008 imem_req_addr  out  32  word-aligned fetch address.
REQ-009 imem_rsp_valid  in  1  instruction data valid; always accepted, at most one per accepted request, no earlier than the cycle after acceptance.
REQ-010 imem_rsp_data  in  32  fetched instruction.
REQ-011 StallD  in  1  decode stage holds; IF/ID register SHALL NOT change.
REQ-012 FlushD  in  1  invalidate IF/ID register.
REQ-013 redirect_valid  in  1  branch/jump taken in execute.
REQ-014 redirect_pc  in  32  new fetch address.
REQ-015 InstrD  out  32  instruction to decode; the controller's instruction input.
REQ-016 PCD  out  32  address of InstrD.
REQ-017 PCPlus4D  out  32  PCD+4, mod 2^32.
REQ-018 ValidD  out  1  InstrD/PCD hold a real instruction.

Function
REQ-019 FSM states: S_REQ (driving request), S_WAIT (one request outstanding), S_HOLD (response held in 1-entry buffer), S_DROP (outstanding response is stale).
REQ-020 At most one request SHALL be outstanding; imem_req_valid=1 only in S_REQ, with imem_req_addr=pc_f.
REQ-021 S_REQ: on valid&ready, pc_f<=pc_f+4 (wraps 32'hFFFF_FFFC->0), capture issued address, go S_WAIT.
REQ-022 S_WAIT, rsp_valid, StallD=0, FlushD=0: load IF/ID at that edge (InstrD=data, PCD=issued address, ValidD=1), go S_REQ; latency request-accept to ValidD is rsp latency + 1 edge.
REQ-023 S_WAIT, rsp_valid with StallD=1 or FlushD=1: store response in buffer, go S_HOLD.
REQ-024 S_HOLD: no request issued; when StallD=0 and FlushD=0, buffer moves to IF/ID, go S_REQ (next request on the following cycle).
REQ-025 IF/ID with StallD=0 and no new load: ValidD<=0, InstrD<=NOP_INSTR (bubble); PCD holds.
REQ-026 FlushD=1: ValidD<=0, InstrD<=NOP_INSTR at next edge; FlushD overrides StallD.
REQ-027 redirect_valid has highest priority: pc_f<=redirect_pc with bits[1:0] forced to 00; IF/ID flushed as REQ-026.
REQ-028 Redirect in S_REQ: the same-cycle request is still issued only if it was accepted before the redirect address is used -- i.e. a request accepted in the redirect cycle SHALL be treated as stale (go S_DROP).
REQ-029 Redirect in S_WAIT or S_DROP: go S_DROP; a coincident rsp_valid in S_WAIT is discarded and the FSM goes S_REQ instead.
REQ-030 Redirect in S_HOLD: buffer discarded, go S_REQ.
REQ-031 S_DROP: on rsp_valid discard data, go S_REQ; IF/ID untouched.
REQ-032 rsp_valid in S_REQ or S_HOLD SHALL be ignored (protocol error, no state change).
REQ-033 PCPlus4D SHALL be combinational PCD+4.

Reset
REQ-034 rst=1 at an edge: state S_REQ, pc_f=RESET_PC, ValidD=0, InstrD=NOP_INSTR, PCD=RESET_PC, buffer empty, imem_req_valid=1 from the first cycle after reset.
REQ-035 Reset mid-operation abandons any outstanding request; instruction memory is reset by the same rst and SHALL NOT return it.

Verification
REQ-036 Zero-wait memory (ready=1, rsp next cycle), no stalls -> addresses 0,4,8,...; ValidD=1 every other cycle with PCD=0,4,8 and matching InstrD.
REQ-037 StallD=1 for 3 cycles while rsp for addr 8 arrives -> S_HOLD, no request issued, InstrD unchanged; on StallD=0, PCD=8 loaded next edge, next request addr 12.
REQ-038 redirect_valid with redirect_pc=32'h0000_0103 while S_WAIT -> stale response discarded, ValidD=0, next request addr 32'h0000_0100.
REQ-039 RESET_PC=32'hFFFF_FFFC -> first request FFFF_FFFC, second 0000_0000; PCPlus4D=0 for the first instruction.
REQ-040 rst asserted in S_HOLD with StallD=1 -> next cycle ValidD=0, InstrD=32'h0000_0013, req addr=RESET_PC.
REQ-041 imem_req_ready=0 for 5 cycles -> imem_req_valid and imem_req_addr held stable, pc_f not advanced.
